wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The module SHALL have parameter STARVE_LIMIT, default 3, giving the number of consecutive denied MUL cycles before MUL is given priority (legal range 1..15).
REQ-002 The module SHALL have parameter ROB_IDX_W, default 4, giving the ROB index width.
REQ-003 Port clk, input, 1: the single clock, rising-edge active.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port flush, input, 1: synchronous pipeline flush.
REQ-006 Ports mem_valid (input, 1), mem_ready (output, 1): request handshake from the MEM/WB-bound path.
REQ-007 Ports mem_rd (input, 5), mem_data (input, 32), mem_we (input, 1), mem_rob_idx (input, ROB_IDX_W): MEM request payload.
REQ-008 Ports mul_valid (input, 1), mul_ready (output, 1): request handshake from the multi-cycle multiplier.
REQ-009 Ports mul_rd (input, 5), mul_data (input, 32), mul_rob_idx (input, ROB_IDX_W): MUL request payload; a MUL result always writes a register.
REQ-010 Ports out_rd (output, 5), out_data (output, 32), out_write_enable (output, 1): register-file write port.
REQ-011 Ports out_complete (output, 1), out_complete_idx (output, ROB_IDX_W): ROB completion port.

Function
REQ-012 A source's handshake SHALL occur on a cycle where its valid and ready are both high; ready SHALL be combinational from the valids, the state and flush.
REQ-013 At most one ready SHALL be high per cycle; both readys SHALL be low while flush=1.
REQ-014 State MEM_PRIO: mem_ready=mem_valid; mul_ready=mul_valid & ~mem_valid.
REQ-015 State MUL_PRIO: mul_ready=mul_valid; mem_ready=mem_valid & ~mul_valid.
REQ-016 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each cycle with mul_valid=1 and mul_ready=0, and SHALL clear on a MUL handshake or when mul_valid=0.
REQ-017 The FSM SHALL move MEM_PRIO->MUL_PRIO on the edge where starve_cnt next reaches STARVE_LIMIT.
REQ-018 The FSM SHALL move MUL_PRIO->MEM_PRIO on a MUL handshake or when mul_valid=0.
REQ-019 Latency SHALL be one cycle: the granted payload appears on the out_* ports at the next rising edge.
REQ-020 On a grant, the registered outputs SHALL be: out_complete=1, out_complete_idx=the granted rob_idx, out_rd and out_data loaded, out_write_enable = (mem_we or 1 for MUL) & (rd != 0).
REQ-021 On a cycle with no grant, out_complete and out_write_enable SHALL be 0 next cycle; out_rd, out_data and out_complete_idx hold their values.
REQ-022 Flush SHALL clear out_complete, out_write_enable and starve_cnt, and SHALL force MEM_PRIO on the next edge; flush overrides any simultaneous request.
REQ-023 Unheld requests SHALL not be dropped: a source keeps valid and payload stable until its handshake.

Reset
REQ-024 While reset_n=0, all outputs, starve_cnt and the state SHALL be 0 / MEM_PRIO immediately, independent of clk.
REQ-025 A request pending at reset assertion SHALL be discarded; no grant occurs on the first edge after reset_n rises unless a valid is presented that cycle.

Configuration
REQ-026 With macro WB_ARBITER_PERF_EN defined, the module SHALL add output perf_conflicts (32 bits), counting cycles where mem_valid and mul_valid are both 1 and flush=0; the counter wraps and resets to 0.
REQ-027 Without WB_ARBITER_PERF_EN, the perf_conflicts port and its counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-028 The state enum (MEM_PRIO, MUL_PRIO), ROB_IDX_W and the writeback payload struct (rd, data, we, rob_idx) SHALL live in the shared core package.
REQ-029 The priority/starvation FSM SHALL be a sub-module wb_prio_fsm; the output register stays in wb_arbiter.

Verification
REQ-030 MEM only: mem_valid=1, rd=5, data=0xDEADBEEF, rob=3 -> next cycle out_write_enable=1, out_rd=5, out_data=0xDEADBEEF, out_complete=1, out_complete_idx=3.
REQ-031 Starvation: both valid for 4 cycles with STARVE_LIMIT=3 -> MEM is granted in cycles 1-3 and MUL in cycle 4, after which the FSM returns to MEM_PRIO.
REQ-032 x0 write: mem rd=0, we=1, rob=7 -> out_write_enable=0, out_complete=1, out_complete_idx=7.
REQ-033 Flush with both valid -> both readys are 0, next cycle out_complete=0, and starve_cnt is 0.
REQ-034 reset_n pulled low mid-cycle with out_complete=1 -> out_complete is 0 before the next clk edge.
REQ-035 PERF_EN: 5 conflict cycles with 1 flushed -> perf_conflicts=4.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-arbiter types: priority state, ROB index width, widths and payload record.
package wb_arbiter_pkg;

    localparam int ROB_IDX_W    = 4;
    localparam int REG_ADDR_W   = 5;
    localparam int DATA_W       = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        MEM_PRIO = 1'b0,
        MUL_PRIO = 1'b1
    } prio_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
        logic                  we;
        logic [ROB_IDX_W-1:0]  rob_idx;
    } wb_payload_t;

    // Register x0 is hardwired to zero, so a write to it is suppressed.
    function automatic logic writes_reg(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != '0);
    endfunction

endpackage

// File: rtl/wb_prio_fsm.sv
// Priority/starvation FSM: MEM normally wins, MUL is boosted after STARVE_LIMIT denied cycles.
module wb_prio_fsm
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic mem_valid,
    input  logic mul_valid,
    output logic mem_ready,
    output logic mul_ready
);

    prio_state_e             state;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] cnt_next;
    logic                    mul_hs;

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
        mem_ready = 1'b0;
        mul_ready = 1'b0;
        if (!flush) begin
            if (state == MUL_PRIO) begin
                mul_ready = mul_valid;
                mem_ready = mem_valid & ~mul_valid;
            end else begin
                mem_ready = mem_valid;
                mul_ready = mul_valid & ~mem_valid;
            end
        end
    end

    assign mul_hs = mul_valid & mul_ready;

    always_comb begin
        cnt_next = '0;
        if (!flush && mul_valid && !mul_ready) begin
            cnt_next = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT)) ? starve_cnt
                                                                   : starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of order.
        if (!reset_n) begin
            state      <= MEM_PRIO;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= cnt_next;
            if (flush) begin
                state <= MEM_PRIO;
            end else begin
                case (state)
                    MEM_PRIO: if (cnt_next == STARVE_CNT_W'(STARVE_LIMIT)) state <= MUL_PRIO;
                    MUL_PRIO: if (mul_hs || !mul_valid) state <= MEM_PRIO;
                    default:  state <= MEM_PRIO;
                endcase
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-source writeback arbiter (MEM vs. multiplier) with a one-cycle registered write/complete port.
// Optional macro WB_ARBITER_PERF_EN adds the perf_conflicts counter output.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int ROB_IDX_W    = wb_arbiter_pkg::ROB_IDX_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    input  logic                  mem_we,
    input  logic [ROB_IDX_W-1:0]  mem_rob_idx,
    input  logic                  mul_valid,
    output logic                  mul_ready,
    input  logic [REG_ADDR_W-1:0] mul_rd,
    input  logic [DATA_W-1:0]     mul_data,
    input  logic [ROB_IDX_W-1:0]  mul_rob_idx,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_write_enable,
    output logic                  out_complete,
    output logic [ROB_IDX_W-1:0]  out_complete_idx
`ifdef WB_ARBITER_PERF_EN
    ,
    output logic [31:0]           perf_conflicts
`endif
);

    logic mem_grant;
    logic mul_grant;

    wb_prio_fsm #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .mem_valid(mem_valid),
        .mul_valid(mul_valid),
        .mem_ready(mem_ready),
        .mul_ready(mul_ready)
    );

    assign mem_grant = mem_valid & mem_ready;
    assign mul_grant = mul_valid & mul_ready;

    // Flush forces both readys low, so a flushed cycle takes the no-grant branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_rd           <= '0;
            out_data         <= '0;
            out_write_enable <= 1'b0;
            out_complete     <= 1'b0;
            out_complete_idx <= '0;
        end else if (mem_grant) begin
            out_rd           <= mem_rd;
            out_data         <= mem_data;
            out_write_enable <= writes_reg(mem_we, mem_rd);
            out_complete     <= 1'b1;
            out_complete_idx <= mem_rob_idx;
        end else if (mul_grant) begin
            out_rd           <= mul_rd;
            out_data         <= mul_data;
            out_write_enable <= writes_reg(1'b1, mul_rd);
            out_complete     <= 1'b1;
            out_complete_idx <= mul_rob_idx;
        end else begin
            out_write_enable <= 1'b0;
            out_complete     <= 1'b0;
        end
    end

`ifdef WB_ARBITER_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_conflicts <= '0;
        end else if (mem_valid && mul_valid && !flush) begin
            perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, corner sequences, randomized model run.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int LIMIT = 3;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          mem_valid, mem_we, mem_ready;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_data;
    logic [IW-1:0] mem_rob_idx;
    logic          mul_valid, mul_ready;
    logic [4:0]    mul_rd;
    logic [31:0]   mul_data;
    logic [IW-1:0] mul_rob_idx;
    logic [4:0]    out_rd;
    logic [31:0]   out_data;
    logic          out_write_enable, out_complete;
    logic [IW-1:0] out_complete_idx;
`ifdef WB_ARBITER_PERF_EN
    logic [31:0]   perf_conflicts;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .ROB_IDX_W   (IW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .mem_we          (mem_we),
        .mem_rob_idx     (mem_rob_idx),
        .mul_valid       (mul_valid),
        .mul_ready       (mul_ready),
        .mul_rd          (mul_rd),
        .mul_data        (mul_data),
        .mul_rob_idx     (mul_rob_idx),
        .out_rd          (out_rd),
        .out_data        (out_data),
        .out_write_enable(out_write_enable),
        .out_complete    (out_complete),
        .out_complete_idx(out_complete_idx)
`ifdef WB_ARBITER_PERF_EN
        ,
        .perf_conflicts  (perf_conflicts)
`endif
    );

    typedef struct {
        logic          mv;
        logic [4:0]    mrd;
        logic [31:0]   mdata;
        logic          mwe;
        logic [IW-1:0] mrob;
        logic          uv;
        logic [4:0]    urd;
        logic [31:0]   udata;
        logic [IW-1:0] urob;
        logic          fl;
        logic          e_mem_rdy;
        logic          e_mul_rdy;
        logic          e_cmp;
        logic          e_we;
        logic [4:0]    e_rd;
        logic [31:0]   e_data;
        logic [IW-1:0] e_idx;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                         input logic mwe, input logic [IW-1:0] mrob, input logic uv,
                         input logic [4:0] urd, input logic [31:0] udata,
                         input logic [IW-1:0] urob, input logic fl);
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdata;  mem_we = mwe;  mem_rob_idx = mrob;
        mul_valid = uv;  mul_rd = urd;  mul_data = udata;  mul_rob_idx = urob;
        flush     = fl;
    endtask

    task automatic check_outs(input string tag, input logic e_cmp, input logic e_we,
                              input logic [4:0] e_rd, input logic [31:0] e_data,
                              input logic [IW-1:0] e_idx);
        check({tag, " out_complete"},     64'(out_complete),     64'(e_cmp));
        check({tag, " out_write_enable"}, 64'(out_write_enable), 64'(e_we));
        check({tag, " out_rd"},           64'(out_rd),           64'(e_rd));
        check({tag, " out_data"},         64'(out_data),         64'(e_data));
        check({tag, " out_complete_idx"}, 64'(out_complete_idx), 64'(e_idx));
    endtask

    // Called at posedge+1 with inputs already driven; returns at the following posedge+1.
    task automatic apply(input string tag, input logic e_mem_rdy, input logic e_mul_rdy,
                         input logic e_cmp, input logic e_we, input logic [4:0] e_rd,
                         input logic [31:0] e_data, input logic [IW-1:0] e_idx);
        #1;
        check({tag, " mem_ready"}, 64'(mem_ready), 64'(e_mem_rdy));
        check({tag, " mul_ready"}, 64'(mul_ready), 64'(e_mul_rdy));
        @(posedge clk);
        #1;
        check_outs(tag, e_cmp, e_we, e_rd, e_data, e_idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_payload_t   exp_q;
        logic          exp_cmp;
        int            mul_wait;
        logic          m_v, u_v, fl, g_mem, g_mul, mul_first;
        logic [4:0]    m_rd, u_rd;
        logic [31:0]   m_data, u_data;
        logic          m_we;
        logic [IW-1:0] m_rob, u_rob;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 4'd3, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 4'd3};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 4'd0, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 4'd3};
        vecs[2] = '{1'b1, 5'd0,  32'h00001234, 1'b1, 4'd7, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  32'h00001234, 4'd7};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 4'd0, 1'b1, 5'd9, 32'hCAFEF00D, 4'd2, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'hCAFEF00D, 4'd2};
        vecs[4] = '{1'b1, 5'd12, 32'h00000055, 1'b0, 4'd1, 1'b0, 5'd0, 32'h0,        4'd0, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 32'h00000055, 4'd1};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 4'd0, 1'b1, 5'd0, 32'h0BADF00D, 4'd4, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0BADF00D, 4'd4};
        vecs[6] = '{1'b1, 5'd6,  32'h00000066, 1'b1, 4'd6, 1'b1, 5'd7, 32'h00000077, 4'd8, 1'b1,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0BADF00D, 4'd4};

        // Asynchronous reset, observed before any clock edge.
        drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_outs("reset", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Directed vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].mv, vecs[i].mrd, vecs[i].mdata, vecs[i].mwe, vecs[i].mrob,
                  vecs[i].uv, vecs[i].urd, vecs[i].udata, vecs[i].urob, vecs[i].fl);
            apply($sformatf("vec%0d", i), vecs[i].e_mem_rdy, vecs[i].e_mul_rdy, vecs[i].e_cmp,
                  vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data, vecs[i].e_idx);
        end

        // Starvation: both valid for 4 cycles -> MEM, MEM, MEM, MUL; then MEM priority again.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(k + 1), 32'(256 + k), 1'b1, 4'(k),
                  1'b1, 5'd20, 32'hA5A50000, 4'd9, 1'b0);
            if (k < 3)
                apply($sformatf("starve%0d", k), 1'b1, 1'b0, 1'b1, 1'b1, 5'(k + 1), 32'(256 + k), 4'(k));
            else
                apply("starve3", 1'b0, 1'b1, 1'b1, 1'b1, 5'd20, 32'hA5A50000, 4'd9);
        end
        drive(1'b1, 5'd10, 32'h200, 1'b1, 4'd10, 1'b1, 5'd21, 32'h77, 4'd11, 1'b0);
        apply("starve_back", 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h200, 4'd10);

        // Flush mid-starvation clears the count: MUL must again wait three denied cycles.
        drive(1'b1, 5'd11, 32'h300, 1'b1, 4'd12, 1'b1, 5'd21, 32'h77, 4'd11, 1'b0);
        apply("pre_flush", 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h300, 4'd12);
        drive(1'b1, 5'd12, 32'h400, 1'b1, 4'd13, 1'b1, 5'd21, 32'h77, 4'd11, 1'b1);
        apply("flush", 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 32'h300, 4'd12);
        check("flush starve_cnt", 64'(dut.u_fsm.starve_cnt), 64'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(12 + k), 32'(1024 + k), 1'b1, 4'(13 + k),
                  1'b1, 5'd21, 32'h77, 4'd11, 1'b0);
            apply($sformatf("post_flush%0d", k), 1'b1, 1'b0, 1'b1, 1'b1,
                  5'(12 + k), 32'(1024 + k), 4'(13 + k));
        end
        drive(1'b1, 5'd15, 32'h500, 1'b1, 4'd0, 1'b1, 5'd21, 32'h77, 4'd11, 1'b0);
        apply("post_flush_mul", 1'b0, 1'b1, 1'b1, 1'b1, 5'd21, 32'h77, 4'd11);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
        apply("idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd21, 32'h77, 4'd11);

        // Reset asserted mid-cycle with out_complete=1, while a MEM request is pending.
        drive(1'b1, 5'd3, 32'h12345678, 1'b1, 4'd5, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
        apply("pre_reset", 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h12345678, 4'd5);
        #2 reset_n = 1'b0;
        #1;
        check_outs("mid_reset", 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
        reset_n = 1'b1;
        apply("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);

`ifdef WB_ARBITER_PERF_EN
        // Five conflict cycles, the third one flushed.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'd1, 32'h1, 1'b1, 4'd1, 1'b1, 5'd2, 32'h2, 4'd2, (k == 2));
            @(posedge clk);
            #1;
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check("perf_conflicts", 64'(perf_conflicts), 64'd4);
`endif

        // Fresh reset, then randomized traffic against the reference model.
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q    = '0;
        exp_cmp  = 1'b0;
        mul_wait = 0;
        m_v = 1'b0; u_v = 1'b0;
        m_rd = '0; m_data = '0; m_we = 1'b0; m_rob = '0;
        u_rd = '0; u_data = '0; u_rob = '0;
        for (int c = 0; c < 400; c++) begin
            if (!m_v && $urandom_range(0, 2) != 0) begin
                m_v    = 1'b1;
                m_rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                m_data = $urandom;
                m_we   = ($urandom_range(0, 3) != 0);
                m_rob  = IW'($urandom_range(0, 15));
            end
            if (!u_v && $urandom_range(0, 2) != 0) begin
                u_v    = 1'b1;
                u_rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                u_data = $urandom;
                u_rob  = IW'($urandom_range(0, 15));
            end
            fl = ($urandom_range(0, 9) == 0);
            drive(m_v, m_rd, m_data, m_we, m_rob, u_v, u_rd, u_data, u_rob, fl);

            // MUL takes priority once it has waited LIMIT consecutive cycles.
            mul_first = (mul_wait >= LIMIT);
            if (fl) begin
                g_mem = 1'b0;
                g_mul = 1'b0;
            end else if (mul_first) begin
                g_mul = u_v;
                g_mem = m_v && !u_v;
            end else begin
                g_mem = m_v;
                g_mul = u_v && !m_v;
            end
            if (fl || !u_v || g_mul) mul_wait = 0;
            else                     mul_wait = mul_wait + 1;

            if (g_mem) begin
                exp_cmp       = 1'b1;
                exp_q.rd      = m_rd;
                exp_q.data    = m_data;
                exp_q.we      = m_we && (m_rd != 5'd0);
                exp_q.rob_idx = m_rob;
            end else if (g_mul) begin
                exp_cmp       = 1'b1;
                exp_q.rd      = u_rd;
                exp_q.data    = u_data;
                exp_q.we      = (u_rd != 5'd0);
                exp_q.rob_idx = u_rob;
            end else begin
                exp_cmp  = 1'b0;
                exp_q.we = 1'b0;
            end

            apply($sformatf("rand%0d", c), g_mem, g_mul, exp_cmp, exp_q.we,
                  exp_q.rd, exp_q.data, exp_q.rob_idx);
            if (g_mem) m_v = 1'b0;
            if (g_mul) u_v = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
